// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, stat codes, register ids
// and the bubble contents of the F/D pipeline register.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Stat codes
  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // Register ids
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Contents of the F/D register
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;

  // Bubble: a nop with no register operands and cleared values
  localparam d_reg_t D_BUBBLE = '{
    stat:  SBUB,
    icode: INOP,
    ifun:  4'h0,
    ra:    RNONE,
    rb:    RNONE,
    valc:  64'h0,
    valp:  64'h0
  };

endpackage

// File: rtl/fetch_stage_f_split.sv
// f_split: combinational split of the ten instruction bytes into fields.
// A memory error turns the instruction into a nop so no operands are used.
module f_split
  import y86_pkg::*;
(
  input  logic [79:0] imem_data_i,
  input  logic        imem_error_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  ra_o,
  output logic [3:0]  rb_o,
  output logic [63:0] valc_o,
  output logic        need_regids_o,
  output logic        need_valc_o,
  output logic        instr_valid_o
);

  logic [3:0] icode_s;

  // Byte 0 decode and operand-presence classification
  always_comb begin
    icode_s       = imem_data_i[7:4];
    ifun_o        = imem_data_i[3:0];
    need_regids_o = 1'b0;
    need_valc_o   = 1'b0;
    if (imem_error_i) begin
      icode_s = INOP;
      ifun_o  = 4'h0;
    end else begin
      icode_s = imem_data_i[7:4];
      ifun_o  = imem_data_i[3:0];
    end
    case (icode_s)
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: need_regids_o = 1'b1;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:    begin need_regids_o = 1'b1; need_valc_o = 1'b1; end
      IJXX, ICALL:                  need_valc_o   = 1'b1;
      default:                      begin need_regids_o = 1'b0; need_valc_o = 1'b0; end
    endcase
  end

  // Register specifiers and constant word extraction
  always_comb begin
    ra_o   = RNONE;
    rb_o   = RNONE;
    valc_o = 64'h0;
    if (need_regids_o) begin
      ra_o = imem_data_i[15:12];
      rb_o = imem_data_i[11:8];
    end else begin
      ra_o = RNONE;
      rb_o = RNONE;
    end
    if (!need_valc_o) begin
      valc_o = 64'h0;
    end else if (need_regids_o) begin
      valc_o = imem_data_i[79:16];
    end else begin
      valc_o = imem_data_i[71:8];
    end
  end

  assign icode_o       = icode_s;
  assign instr_valid_o = (icode_s <= IPOPQ);

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: Y86-64 fetch with PC selection, predicted-PC register and
// the F/D pipeline register.
// Optional macro FETCH_HALT_FREEZE_EN: once a halt/error instruction enters
// D, fetch freezes (PC held, D fed bubbles) until reset.
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  output logic [63:0] imem_addr,
  input  logic [79:0] imem_data,
  input  logic        imem_error,
  output logic [63:0] f_predPC,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP
);

  logic [63:0] f_pc_s;
  logic [3:0]  icode_s;
  logic [3:0]  ifun_s;
  logic [3:0]  ra_s;
  logic [3:0]  rb_s;
  logic [63:0] valc_s;
  logic [63:0] valp_s;
  logic        need_regids_s;
  logic        need_valc_s;
  logic        instr_valid_s;
  logic [2:0]  f_stat_s;
  logic [63:0] pred_pc_q;
  d_reg_t      d_q;
  d_reg_t      d_d;
  logic        frozen_s;
  logic        d_load_s;

  // PC select: mispredicted jump beats return, otherwise use the prediction
  always_comb begin
    f_pc_s = pred_pc_q;
    if ((M_icode == IJXX) && !M_Cnd) begin
      f_pc_s = M_valA;
    end else if (W_icode == IRET) begin
      f_pc_s = W_valM;
    end else begin
      f_pc_s = pred_pc_q;
    end
  end

  f_split u_f_split (
    .imem_data_i   (imem_data),
    .imem_error_i  (imem_error),
    .icode_o       (icode_s),
    .ifun_o        (ifun_s),
    .ra_o          (ra_s),
    .rb_o          (rb_s),
    .valc_o        (valc_s),
    .need_regids_o (need_regids_s),
    .need_valc_o   (need_valc_s),
    .instr_valid_o (instr_valid_s)
  );

  // Fall-through address, status and next-PC prediction
  always_comb begin
    valp_s = f_pc_s + 64'd1 + {63'd0, need_regids_s} + (need_valc_s ? 64'd8 : 64'd0);
    if (imem_error) begin
      f_stat_s = SADR;
    end else if (!instr_valid_s) begin
      f_stat_s = SINS;
    end else if (icode_s == IHALT) begin
      f_stat_s = SHLT;
    end else begin
      f_stat_s = SAOK;
    end
    if ((icode_s == IJXX) || (icode_s == ICALL)) begin
      f_predPC = valc_s;
    end else begin
      f_predPC = valp_s;
    end
  end

  // D next-state: hold on stall, bubble on request or freeze, else load
  always_comb begin
    d_d      = d_q;
    d_load_s = 1'b0;
    if (D_stall) begin
      d_d = d_q;
    end else if (D_bubble || frozen_s) begin
      d_d = D_BUBBLE;
    end else begin
      d_load_s = 1'b1;
      d_d      = '{stat: f_stat_s, icode: icode_s, ifun: ifun_s, ra: ra_s,
                   rb: rb_s, valc: valc_s, valp: valp_s};
    end
  end

`ifdef FETCH_HALT_FREEZE_EN
  logic frozen_q;

  // Sticky freeze once a non-AOK instruction is loaded into D
  always_ff @(posedge clk) begin
    if (rst) begin
      frozen_q <= 1'b0;
    end else if (d_load_s && (f_stat_s != SAOK)) begin
      frozen_q <= 1'b1;
    end else begin
      frozen_q <= frozen_q;
    end
  end

  assign frozen_s = frozen_q;
`else
  assign frozen_s = 1'b0;
`endif

  // Predicted-PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_pc_q <= RESET_PC;
    end else if (!F_stall && !frozen_s) begin
      pred_pc_q <= f_predPC;
    end else begin
      pred_pc_q <= pred_pc_q;
    end
  end

  // F/D pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= D_BUBBLE;
    end else begin
      d_q <= d_d;
    end
  end

  assign imem_addr = f_pc_s;
  assign D_stat    = d_q.stat;
  assign D_icode   = d_q.icode;
  assign D_ifun    = d_q.ifun;
  assign D_rA      = d_q.ra;
  assign D_rB      = d_q.rb;
  assign D_valC    = d_q.valc;
  assign D_valP    = d_q.valp;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stimulus, all checked against a byte-level reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_stall, D_stall, D_bubble;
  logic [3:0]  M_icode, W_icode;
  logic        M_Cnd;
  logic [63:0] M_valA, W_valM;
  logic [63:0] imem_addr;
  logic [79:0] imem_data;
  logic        imem_error;
  logic [63:0] f_predPC;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_init = 1'b0;
  logic        m_frozen = 1'b0;
  logic [63:0] m_predpc;
  logic [2:0]  md_stat;
  logic [3:0]  md_icode, md_ifun, md_ra, md_rb;
  logic [63:0] md_valc, md_valp;

  localparam logic [79:0] IRMOV_DATA = {56'h0, 8'h01, 8'h00, 8'hF0, 8'h30};
  localparam logic [79:0] JXX_DATA   = {64'h0, 8'h80, 8'h70};
  localparam logic [79:0] NOP_DATA   = {72'h0, 8'h10};

  fetch_stage #(.RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA), .W_icode(W_icode), .W_valM(W_valM),
    .imem_addr(imem_addr), .imem_data(imem_data), .imem_error(imem_error),
    .f_predPC(f_predPC), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decode ten bytes the way the ISA describes the instruction layout
  function automatic void ref_fetch(input logic [79:0] data, input logic err, input logic [63:0] pc,
                                    output logic [2:0] st, output logic [3:0] ic, output logic [3:0] ifn,
                                    output logic [3:0] ra, output logic [3:0] rb,
                                    output logic [63:0] vc, output logic [63:0] vp, output logic [63:0] np);
    logic [7:0] b [10];
    logic regs, cval;
    int start;
    for (int k = 0; k < 10; k++) b[k] = data[8*k +: 8];
    ic   = err ? 4'h1 : b[0][7:4];
    ifn  = err ? 4'h0 : b[0][3:0];
    regs = ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    cval = ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    ra   = regs ? b[1][7:4] : 4'hF;
    rb   = regs ? b[1][3:0] : 4'hF;
    vc   = 64'h0;
    if (cval) begin
      start = regs ? 2 : 1;
      for (int k = 0; k < 8; k++) vc = vc | (64'(b[start+k]) << (8*k));
    end
    vp = pc + 64'd1 + (regs ? 64'd1 : 64'd0) + (cval ? 64'd8 : 64'd0);
    if (err) st = 3'd3;
    else if (ic > 4'hB) st = 3'd4;
    else if (ic == 4'h0) st = 3'd2;
    else st = 3'd1;
    np = (ic == 4'h7 || ic == 4'h8) ? vc : vp;
  endfunction

  task automatic drive(input logic r, input logic fs, input logic ds, input logic db,
                       input logic [3:0] mi, input logic mc, input logic [63:0] mv,
                       input logic [3:0] wi, input logic [63:0] wv,
                       input logic [79:0] data, input logic err);
    rst = r; F_stall = fs; D_stall = ds; D_bubble = db;
    M_icode = mi; M_Cnd = mc; M_valA = mv; W_icode = wi; W_valM = wv;
    imem_data = data; imem_error = err;
  endtask

  // One clock: check combinational outputs, advance model, check D outputs
  task automatic cycle();
    logic [63:0] pc, vc, vp, np;
    logic [2:0]  st;
    logic [3:0]  ic, ifn, ra, rb;
    #1;
    if (M_icode == 4'h7 && M_Cnd == 1'b0) pc = M_valA;
    else if (W_icode == 4'h9) pc = W_valM;
    else pc = m_predpc;
    ref_fetch(imem_data, imem_error, pc, st, ic, ifn, ra, rb, vc, vp, np);
    if (m_init) begin
      check("imem_addr", imem_addr, pc);
      check("f_predPC", f_predPC, np);
    end
    @(posedge clk);
    if (rst) begin
      m_init = 1'b1; m_frozen = 1'b0; m_predpc = 64'h0;
      md_stat = 3'd0; md_icode = 4'h1; md_ifun = 4'h0; md_ra = 4'hF; md_rb = 4'hF;
      md_valc = 64'h0; md_valp = 64'h0;
    end else begin
      if (!F_stall && !m_frozen) m_predpc = np;
      if (D_stall) begin
        // D keeps its contents
      end else if (D_bubble || m_frozen) begin
        md_stat = 3'd0; md_icode = 4'h1; md_ifun = 4'h0; md_ra = 4'hF; md_rb = 4'hF;
        md_valc = 64'h0; md_valp = 64'h0;
      end else begin
        md_stat = st; md_icode = ic; md_ifun = ifn; md_ra = ra; md_rb = rb;
        md_valc = vc; md_valp = vp;
`ifdef FETCH_HALT_FREEZE_EN
        if (st != 3'd1) m_frozen = 1'b1;
`endif
      end
    end
    #1;
    if (m_init) begin
      check("D_stat", 64'(D_stat), 64'(md_stat));
      check("D_icode", 64'(D_icode), 64'(md_icode));
      check("D_ifun", 64'(D_ifun), 64'(md_ifun));
      check("D_rA", 64'(D_rA), 64'(md_ra));
      check("D_rB", 64'(D_rB), 64'(md_rb));
      check("D_valC", D_valC, md_valc);
      check("D_valP", D_valP, md_valp);
    end
    @(negedge clk);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0, NOP_DATA, 1'b0);
    @(negedge clk);

    // Reset
    cycle();
    check("rst_stat", 64'(D_stat), 64'd0);
    check("rst_icode", 64'(D_icode), 64'd1);
    check("rst_rA", 64'(D_rA), 64'hF);
    check("rst_rB", 64'(D_rB), 64'hF);

    // irmovq $0x100, %rax at PC 0
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0, IRMOV_DATA, 1'b0);
    #1;
    check("rst_addr", imem_addr, 64'h0);
    check("irmov_pred", f_predPC, 64'd10);
    cycle();
    check("irmov_icode", 64'(D_icode), 64'd3);
    check("irmov_rB", 64'(D_rB), 64'd0);
    check("irmov_valC", D_valC, 64'h100);
    check("irmov_valP", D_valP, 64'd10);

    // Jump at 0x20 (reached via a return) predicts its target
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 4'h9, 64'h20, JXX_DATA, 1'b0);
    #1;
    check("jxx_addr", imem_addr, 64'h20);
    check("jxx_pred", f_predPC, 64'h80);
    cycle();

    // Mispredict redirect, return redirect, and mispredict beating return
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 1'b0, 64'h29, 4'h0, 64'h0, NOP_DATA, 1'b0);
    #1;
    check("mispred_addr", imem_addr, 64'h29);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 4'h9, 64'h400, NOP_DATA, 1'b0);
    #1;
    check("ret_addr", imem_addr, 64'h400);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 1'b0, 64'h29, 4'h9, 64'h400, NOP_DATA, 1'b0);
    #1;
    check("mispred_over_ret", imem_addr, 64'h29);
    cycle();

    // Memory error, then invalid instruction after a fresh reset
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0, IRMOV_DATA, 1'b1);
    cycle();
    check("err_stat", 64'(D_stat), 64'd3);
    check("err_icode", 64'(D_icode), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0, NOP_DATA, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0, {72'h0, 8'hC0}, 1'b0);
    cycle();
    check("ins_stat", 64'(D_stat), 64'd4);

    // Stall beats bubble; bubble alone; fetch stall
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0, IRMOV_DATA, 1'b0);
    cycle();
    check("stall_hold", 64'(D_stat), 64'd4);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0, IRMOV_DATA, 1'b0);
    cycle();
    check("bubble_stat", 64'(D_stat), 64'd0);
    check("bubble_icode", 64'(D_icode), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0, NOP_DATA, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0, IRMOV_DATA, 1'b0);
    cycle();
    cycle();
    check("fstall_addr", imem_addr, 64'h0);

    // Halt, then keep fetching (freeze behaviour depends on build)
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0, {72'h0, 8'h00}, 1'b0);
    cycle();
    check("halt_stat", 64'(D_stat), 64'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0, IRMOV_DATA, 1'b0);
    cycle();
    cycle();
`ifdef FETCH_HALT_FREEZE_EN
    check("frozen_icode", 64'(D_icode), 64'd1);
    check("frozen_addr", imem_addr, 64'h1);
`else
    check("nofreeze_icode", 64'(D_icode), 64'd3);
`endif

    // Random stimulus
    for (int n = 0; n < 3000; n++) begin
      logic [79:0] data;
      data = {16'($urandom), $urandom, $urandom};
      data[7:4] = 4'($urandom_range(0, 12));
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 0 ? 4'h7 : 4'($urandom),
            1'($urandom),
            {$urandom, $urandom},
            $urandom_range(0, 3) == 0 ? 4'h9 : 4'($urandom),
            {$urandom, $urandom},
            data,
            $urandom_range(0, 15) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
